// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared widths, opcodes and result-register states for alu_arb
package alu_arb_pkg;

  localparam int ID_W   = 1;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_ADD = 2'b00;
  localparam opcode_t OP_SUB = 2'b01;
  localparam opcode_t OP_AND = 2'b10;
  localparam opcode_t OP_OR  = 2'b11;

  // Result register occupancy doubles as the state: EMPTY or FULL
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

endpackage

// File: rtl/alu_arb_alu.sv
// rtl/alu_arb_alu.sv - shared 8-bit combinational alu with signed overflow flag
module alu
  import alu_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_t           op,
  output logic [DATA_W-1:0] c,
  output logic              overflow
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Select result; overflow only meaningful for the signed arithmetic ops
  always_comb begin
    c        = '0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        c        = sum;
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        c        = diff;
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  c = a & b;
      default: c = a | b;
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - two-requester round-robin front end for the shared alu; stats under ALU_ARB_STATS_EN
module alu_arb
  import alu_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              v0,
  input  logic              v1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  input  logic [1:0]        op0,
  input  logic [1:0]        op1,
  output logic              rdy0,
  output logic              rdy1,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ID_W-1:0]   res_id,
  output logic [DATA_W-1:0] c,
  output logic              overflow,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  ovf_cnt
);

  logic              last;
  logic              can_accept;
  logic              gnt0;
  logic              gnt1;
  logic              grant;
  logic [ID_W-1:0]   gnt_id;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  opcode_t           alu_op;
  logic [DATA_W-1:0] alu_c;
  logic              alu_ovf;

  // A slot opens when the register is empty or is being drained this cycle
  assign can_accept = !res_valid || res_ready;

  // Round-robin grant: a lone requester wins, contention goes to the one not served last
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && can_accept) begin
      if (v0 && v1) begin
        if (last) gnt0 = 1'b1;
        else      gnt1 = 1'b1;
      end else if (v0) begin
        gnt0 = 1'b1;
      end else if (v1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign rdy0   = gnt0;
  assign rdy1   = gnt1;
  assign grant  = gnt0 | gnt1;
  assign gnt_id = gnt1;

  // Operand mux feeding the single alu; requester 0 is the idle default
  always_comb begin
    alu_a  = a0;
    alu_b  = b0;
    alu_op = op0;
    if (gnt1) begin
      alu_a  = a1;
      alu_b  = b1;
      alu_op = op1;
    end
  end

  alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .op       (alu_op),
    .c        (alu_c),
    .overflow (alu_ovf)
  );

  // Result register: load on grant, clear on drain, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= S_EMPTY;
      c         <= '0;
      overflow  <= 1'b0;
      res_id    <= '0;
      last      <= 1'b1;
    end else if (grant) begin
      res_valid <= S_FULL;
      c         <= alu_c;
      overflow  <= alu_ovf;
      res_id    <= gnt_id;
      last      <= gnt1;
    end else if (res_ready) begin
      res_valid <= S_EMPTY;
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Free-running wrap-around grant and overflow counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0    <= '0;
      cnt1    <= '0;
      ovf_cnt <= '0;
    end else begin
      if (gnt0)            cnt0    <= cnt0 + CNT_W'(1);
      if (gnt1)            cnt1    <= cnt1 + CNT_W'(1);
      if (grant && alu_ovf) ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end
`else
  assign cnt0    = '0;
  assign cnt1    = '0;
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// tb/tb_alu_arb.sv - randomized self-checking bench for alu_arb against an arithmetic reference model
module tb_alu_arb;
  import alu_arb_pkg::*;

`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic        rdy0, rdy1, res_valid, res_id, overflow;
  logic        res_ready = 1'b0;
  logic [7:0]  c;
  logic [15:0] cnt0, cnt1, ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_valid = 1'b0, m_ovf = 1'b0, m_id = 1'b0, m_last = 1'b1;
  logic [7:0]  m_c = '0;
  logic [15:0] m_cnt0 = '0, m_cnt1 = '0, m_ovfc = '0;
  logic [1:0]  exp_gnt, obs_gnt;
  logic [10:0] exp_res;
  logic [47:0] exp_cnt;

  alu_arb dut (
    .clk(clk), .rst(rst), .v0(v0), .v1(v1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .op0(op0), .op1(op1), .rdy0(rdy0), .rdy1(rdy1), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .c(c), .overflow(overflow),
    .cnt0(cnt0), .cnt1(cnt1), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  // Arithmetic with plain integers; overflow means the true result leaves [-128,127]
  function automatic void ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic o);
    int sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    s  = 0;
    case (op)
      2'd0:    s = sa + sb;
      2'd1:    s = sa - sb;
      2'd2:    s = int'(a & b);
      default: s = int'(a | b);
    endcase
    r = s[7:0];
    o = (op < 2'd2) && ((s > 127) || (s < -128));
  endfunction

  // One clock: sample grants mid-cycle, advance model at the edge, settle after it
  task automatic tick();
    logic [7:0] r;
    logic       o;
    int         w;
    @(negedge clk);
    obs_gnt = {rdy0, rdy1};
    w = -1;
    if (!rst && (!m_valid || res_ready)) begin
      if (v0 && v1) w = m_last ? 0 : 1;
      else if (v0)  w = 0;
      else if (v1)  w = 1;
    end
    exp_gnt = (w == 0) ? 2'b10 : (w == 1) ? 2'b01 : 2'b00;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_c = '0; m_ovf = 1'b0; m_id = 1'b0; m_last = 1'b1;
      m_cnt0 = '0; m_cnt1 = '0; m_ovfc = '0;
    end else if (w >= 0) begin
      if (w == 0) ref_alu(op0, a0, b0, r, o);
      else        ref_alu(op1, a1, b1, r, o);
      m_valid = 1'b1; m_c = r; m_ovf = o; m_id = (w == 1); m_last = (w == 1);
      if (w == 0) m_cnt0 = m_cnt0 + 16'd1;
      else        m_cnt1 = m_cnt1 + 16'd1;
      if (o) m_ovfc = m_ovfc + 16'd1;
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    exp_res = {m_valid, m_c, m_ovf, m_id};
    exp_cnt = STATS ? {m_cnt0, m_cnt1, m_ovfc} : 48'd0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; res_ready = 1'b1;
    tick();
    n_checks++;
    if (obs_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_rdy got=%b want=00", obs_gnt); end
    n_checks++;
    if ({res_valid, c, overflow, res_id} !== 11'd0) begin
      n_fail++; $display("FAIL reset_result got=%b_%h_%b_%b want=0_00_0_0", res_valid, c, overflow, res_id);
    end
    n_checks++;
    if ({cnt0, cnt1, ovf_cnt} !== 48'd0) begin
      n_fail++; $display("FAIL reset_cnt got=%h/%h/%h want=0", cnt0, cnt1, ovf_cnt);
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic test_single();
    v0 = 1'b1; a0 = 8'h05; b0 = 8'h03; op0 = 2'b00; v1 = 1'b0; res_ready = 1'b1;
    tick();
    n_checks++;
    if (obs_gnt !== 2'b10) begin n_fail++; $display("FAIL single_rdy got=%b want=10", obs_gnt); end
    n_checks++;
    if ({res_valid, c, overflow, res_id} !== {1'b1, 8'h08, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_result got=%b_%h_%b_%b want=1_08_0_0", res_valid, c, overflow, res_id);
    end
    v0 = 1'b0;
  endtask

  task automatic test_overflow();
    v1 = 1'b1; a1 = 8'h7F; b1 = 8'h01; op1 = 2'b00; res_ready = 1'b1;
    tick();
    n_checks++;
    if (obs_gnt !== 2'b01) begin n_fail++; $display("FAIL ovf_rdy got=%b want=01", obs_gnt); end
    n_checks++;
    if ({res_valid, c, overflow, res_id} !== {1'b1, 8'h80, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL ovf_result got=%b_%h_%b_%b want=1_80_1_1", res_valid, c, overflow, res_id);
    end
    n_checks++;
    if (ovf_cnt !== (STATS ? 16'd1 : 16'd0)) begin
      n_fail++; $display("FAIL ovf_cnt got=%0d want=%0d", ovf_cnt, STATS ? 1 : 0);
    end
    v1 = 1'b0;
  endtask

  task automatic test_contention();
    logic [1:0] want;
    rst = 1'b1; tick(); rst = 1'b0;
    v0 = 1'b1; v1 = 1'b1; res_ready = 1'b1;
    a0 = 8'($urandom); b0 = 8'($urandom); op0 = 2'($urandom);
    a1 = 8'($urandom); b1 = 8'($urandom); op1 = 2'($urandom);
    for (int i = 0; i < 6; i++) begin
      tick();
      want = (i % 2 == 0) ? 2'b10 : 2'b01;
      n_checks++;
      if (obs_gnt !== want) begin n_fail++; $display("FAIL contention_order[%0d] got=%b want=%b", i, obs_gnt, want); end
      n_checks++;
      if ({res_valid, c, overflow, res_id} !== exp_res) begin
        n_fail++; $display("FAIL contention_result[%0d] got=%b_%h_%b_%b want=%h", i, res_valid, c, overflow, res_id, exp_res);
      end
      if (obs_gnt[1]) begin a0 = 8'($urandom); b0 = 8'($urandom); op0 = 2'($urandom); end
      if (obs_gnt[0]) begin a1 = 8'($urandom); b1 = 8'($urandom); op1 = 2'($urandom); end
    end
    n_checks++;
    if ({cnt0, cnt1} !== (STATS ? {16'd3, 16'd3} : 32'd0)) begin
      n_fail++; $display("FAIL contention_cnt got=%0d/%0d want=%0d each", cnt0, cnt1, STATS ? 3 : 0);
    end
    n_checks++;
    if (ovf_cnt !== exp_cnt[15:0]) begin n_fail++; $display("FAIL contention_ovfcnt got=%0d want=%0d", ovf_cnt, exp_cnt[15:0]); end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] held_c, new_c;
    logic       new_o;
    v0 = 1'b1; v1 = 1'b0; a0 = 8'h40; b0 = 8'h22; op0 = 2'b01; res_ready = 1'b1;
    tick();
    held_c = m_c;
    a0 = 8'($urandom); b0 = 8'($urandom); op0 = 2'($urandom); res_ready = 1'b0;
    ref_alu(op0, a0, b0, new_c, new_o);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs_gnt !== 2'b00) begin n_fail++; $display("FAIL hold_rdy[%0d] got=%b want=00", i, obs_gnt); end
      n_checks++;
      if ({res_valid, c} !== {1'b1, held_c}) begin
        n_fail++; $display("FAIL hold_c[%0d] got=%b_%h want=1_%h", i, res_valid, c, held_c);
      end
    end
    res_ready = 1'b1;
    tick();
    n_checks++;
    if (obs_gnt !== 2'b10) begin n_fail++; $display("FAIL release_rdy got=%b want=10", obs_gnt); end
    n_checks++;
    if ({res_valid, c, overflow, res_id} !== {1'b1, new_c, new_o, 1'b0}) begin
      n_fail++; $display("FAIL release_result got=%b_%h_%b_%b want=1_%h_%b_0", res_valid, c, overflow, res_id, new_c, new_o);
    end
    v0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    v0 = 1'b1; v1 = 1'b0; res_ready = 1'b1;
    tick();
    v1 = 1'b1; res_ready = 1'b0; rst = 1'b1;
    tick();
    n_checks++;
    if (obs_gnt !== 2'b00) begin n_fail++; $display("FAIL midreset_rdy got=%b want=00", obs_gnt); end
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got=%b want=0", res_valid); end
    n_checks++;
    if ({cnt0, cnt1, ovf_cnt} !== 48'd0) begin
      n_fail++; $display("FAIL midreset_cnt got=%h/%h/%h want=0", cnt0, cnt1, ovf_cnt);
    end
    rst = 1'b0; res_ready = 1'b1;
    tick();
    n_checks++;
    if (obs_gnt !== 2'b10) begin n_fail++; $display("FAIL midreset_first got=%b want=10", obs_gnt); end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic test_random();
    logic done0 = 1'b1, done1 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!v0 || done0) begin v0 = 1'($urandom); a0 = 8'($urandom); b0 = 8'($urandom); op0 = 2'($urandom); end
      if (!v1 || done1) begin v1 = 1'($urandom); a1 = 8'($urandom); b1 = 8'($urandom); op1 = 2'($urandom); end
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
      done0 = obs_gnt[1];
      done1 = obs_gnt[0];
      n_checks++;
      if (obs_gnt !== exp_gnt) begin n_fail++; $display("FAIL rand_rdy[%0d] got=%b want=%b", i, obs_gnt, exp_gnt); end
      n_checks++;
      if ({res_valid, c, overflow, res_id} !== exp_res) begin
        n_fail++; $display("FAIL rand_result[%0d] got=%b_%h_%b_%b want=%h", i, res_valid, c, overflow, res_id, exp_res);
      end
      n_checks++;
      if ({cnt0, cnt1, ovf_cnt} !== exp_cnt) begin
        n_fail++; $display("FAIL rand_cnt[%0d] got=%h/%h/%h want=%h", i, cnt0, cnt1, ovf_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
# alu_arb

Two-requester round-robin arbiter and sequencer for the shared 8-bit `alu`. It accepts operand/opcode transactions from two independent requesters over valid/ready handshakes and issues at most one per cycle to the single `alu` instance. Each result is registered with its source ID and overflow flag and held until the downstream consumer accepts it. The block sits between the two operand-producing front ends and the result sink.

## Interface
- No parameters; widths are fixed: operand 8, opcode 2, requester ID 1.
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `v0`, `v1`  in  1  requester 0/1 transaction valid
- `a0`, `b0`, `a1`, `b1`  in  8  operands per requester
- `op0`, `op1`  in  2  opcode per requester, passed to `alu` unmodified
- `rdy0`, `rdy1`  out  1  requester 0/1 transaction accepted this cycle
- `res_valid`  out  1  result register holds a valid result
- `res_ready`  in  1  consumer accepts result this cycle
- `res_id`  out  1  source requester of held result
- `c`  out  8  held ALU result
- `overflow`  out  1  held ALU overflow flag
- `cnt0`, `cnt1`  out  16  grant counters (see Configuration)
- `ovf_cnt`  out  16  overflow counter (see Configuration)

## Operation
- Transfer on requester k occurs when `vk && rdyk` in the same cycle. Requesters hold `vk`, operands and opcode stable until `rdyk`.
- `can_accept = !res_valid || res_ready`.
- Grant logic is combinational from `v0`, `v1`, `last` and `can_accept`:
  - At most one of `rdy0`/`rdy1` is high.
  - Neither is high when `!can_accept`.
  - Single valid requester: that requester is granted.
  - Both valid: grant goes to `!last`.
- On a grant:
  - The granted operands and opcode drive `alu` in the same cycle.
  - `c`, `overflow` and `res_id` are captured from the ALU output at the next edge; `res_valid` is set.
  - `last` updates to the granted ID.
- Drain: when `res_valid && res_ready` with no new grant, `res_valid` clears at the next edge. A grant in the same cycle keeps `res_valid` at 1 and loads the new result, giving back-to-back throughput.
- Held outputs `c`, `overflow` and `res_id` do not change while `res_valid && !res_ready`.
- Outputs are undefined-free: the register holds its last value when `res_valid` is 0.
- States are encoded by `res_valid`:
  - EMPTY(0) → FULL on a grant.
  - FULL(1) → EMPTY on drain with no grant.
  - FULL → FULL on a hold, or on drain with a grant.
- Arithmetic and overflow semantics are owned by `alu`. Opcode 00 is 8-bit add; overflow is signed two's-complement overflow.

## Timing
- Reset values: `res_valid`=0, `c`=0, `overflow`=0, `res_id`=0, `last`=1 (requester 0 wins the first contention), `cnt0`=`cnt1`=`ovf_cnt`=0.
- `rdy0`/`rdy1` are 0 during the cycle `rst` is high.
- Latency: 1 cycle from transfer to `res_valid`.
- Throughput: 1 transaction/cycle while `res_ready`=1.
- Under continuous contention, grants alternate 0,1,0,1.
- Reset mid-operation drops the held result; in-flight requests are not acknowledged.
- `res_ready` with `res_valid`=0 is ignored.

## Configuration
- Macro `ALU_ARB_STATS_EN`.
- Defined:
  - `cnt0`/`cnt1` increment on each transfer from requester 0/1.
  - `ovf_cnt` increments at each result capture with `overflow`=1.
  - All counters are 16-bit and wrap from 0xFFFF to 0x0000.
  - All counters clear on `rst`.
- Undefined: the counter registers are not built and the three ports are tied to 0. The ports remain present.

## Structure
- Package `alu_arb_pkg` holds:
  - opcode constants `OP_ADD`=2'b00, `OP_SUB`=2'b01, `OP_AND`=2'b10, `OP_OR`=2'b11
  - `ID_W`=1, `DATA_W`=8, `CNT_W`=16
- One sub-module: the existing `alu`, instantiated once on the granted operand mux. The arbiter, mux and result register are in `alu_arb`.

## Test plan
- Reset, then `v0`=1, `a0`=8'h05, `b0`=8'h03, `op0`=00, `res_ready`=1 → `rdy0`=1; next cycle `res_valid`=1, `c`=8'h08, `overflow`=0, `res_id`=0.
- `a1`=8'h7F, `b1`=8'h01, `op1`=00 on requester 1 alone → `c`=8'h80, `overflow`=1, `res_id`=1, and `ovf_cnt`=1 when `ALU_ARB_STATS_EN` is defined.
- Both valid continuously for 6 cycles with `res_ready`=1 → grants in order 0,1,0,1,0,1; `cnt0`=`cnt1`=3.
- Result FULL with `res_ready`=0 for 4 cycles while `v0`=1 → `rdy0`=0 throughout and `c` stable; raising `res_ready` gives `rdy0`=1 that cycle and the new result the next cycle with no bubble.
- Assert `rst` while `res_valid`=1 and both requesters valid → next cycle `res_valid`=0, counters 0; the first contention after reset grants requester 0.
- With `ALU_ARB_STATS_EN` undefined, run the contention scenario → `cnt0`, `cnt1` and `ovf_cnt` stay 0.
